// File: rtl/vga_terminal.sv
// Text-mode VGA terminal: circular row buffer, command port, blinking cursor
// and a two-stage pixel pipeline fed by an external hvsync generator.
module vga_terminal #(
   parameter int COLS      = 80,
   parameter int ROWS      = 30,
   parameter int BLINK_DIV = 12500000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [9:0]  hpos,
   input  logic [9:0]  vpos,
   input  logic        display_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [7:0]  cmd_data,
   input  logic [11:0] fgclr,
   input  logic [11:0] bgclr,
   input  logic        underln,
   input  logic        curvis,
   input  logic        curblk,
   output logic [4:0]  cur_row,
   output logic [6:0]  cur_col,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue
);
   localparam int CELLS = ROWS * COLS;
   localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CLEAR  = 2'd1;
   localparam logic [1:0] ST_SCROLL = 2'd2;

   localparam logic [2:0] OP_PUTC   = 3'd0;
   localparam logic [2:0] OP_SETROW = 3'd1;
   localparam logic [2:0] OP_SETCOL = 3'd2;
   localparam logic [2:0] OP_CLEAR  = 3'd3;

   localparam logic [4:0]    LAST_ROW    = 5'(ROWS - 1);
   localparam logic [6:0]    LAST_COL    = 7'(COLS - 1);
   localparam logic [7:0]    LAST_ROW8   = 8'(ROWS - 1);
   localparam logic [7:0]    LAST_COL8   = 8'(COLS - 1);
   localparam logic [AW-1:0] LAST_CELL   = AW'(CELLS - 1);
   localparam logic [AW-1:0] LAST_SCROLL = AW'(COLS - 1);
   localparam logic [31:0]   LAST_BLINK  = 32'(BLINK_DIV - 1);

   // Logical screen row to physical buffer row, rotated by the top offset.
   function automatic logic [4:0] phys_row(input int lrow, input logic [4:0] t);
      int s;
      s = lrow + int'(t);
      if (s >= ROWS) s = s - ROWS;
      return s[4:0];
   endfunction

   function automatic logic [AW-1:0] cell_addr(input logic [4:0] prow, input int col);
      int a;
      a = int'(prow) * COLS + col;
      return a[AW-1:0];
   endfunction

   // Built-in glyphs: 'A', blank for 0x00/0x20, a hollow box for everything else.
   function automatic logic [7:0] font_row(input logic [7:0] ch, input logic [3:0] row);
      logic [7:0] g;
      g = 8'h00;
      if (ch == 8'h41) begin
         case (row)
            4'd1:                         g = 8'h18;
            4'd2:                         g = 8'h3C;
            4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9: g = 8'h66;
            4'd5:                         g = 8'h7E;
            default:                      g = 8'h00;
         endcase
      end else if (ch != 8'h00 && ch != 8'h20) begin
         case (row)
            4'd1, 4'd10:                         g = 8'h7E;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: g = 8'h42;
            default:                             g = 8'h00;
         endcase
      end
      return g;
   endfunction

   logic [1:0]    state;
   logic [AW-1:0] cnt;
   logic [4:0]    top, scroll_row, row_q;
   logic [6:0]    col_q;
   logic          accept, is_putc, printable, do_lf;
   logic          we;
   logic [AW-1:0] wa;
   logic [32:0]   wd;
   logic [32:0]   mem [CELLS];

   assign cmd_ready = (state == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign is_putc   = accept && (cmd_op == OP_PUTC);
   assign printable = (cmd_data >= 8'h20) || (cmd_data <= 8'h07);
   assign do_lf     = is_putc && ((cmd_data == 8'h0A) || (printable && col_q == LAST_COL));
   assign cur_row   = row_q;
   assign cur_col   = col_q;

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      we = 1'b0;
      wa = '0;
      wd = '0;
      case (state)
         ST_CLEAR:  begin we = 1'b1; wa = cnt; end
         ST_SCROLL: begin we = 1'b1; wa = cell_addr(scroll_row, int'(cnt)); end
         default: if (is_putc && printable) begin
            we = 1'b1;
            wa = cell_addr(phys_row(int'(row_q), top), int'(col_q));
            wd = {underln, fgclr, bgclr, cmd_data};
         end
      endcase
   end

   // NOTE: the buffer has no reset; every reset release runs CLEAR over it.
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_CLEAR;
         cnt        <= '0;
         top        <= '0;
         scroll_row <= '0;
         row_q      <= '0;
         col_q      <= '0;
      end else begin
         case (state)
            ST_CLEAR:
               if (cnt == LAST_CELL) begin state <= ST_IDLE; cnt <= '0; end
               else cnt <= cnt + 1'b1;
            ST_SCROLL:
               if (cnt == LAST_SCROLL) begin state <= ST_IDLE; cnt <= '0; end
               else cnt <= cnt + 1'b1;
            default: if (accept) begin
               case (cmd_op)
                  OP_PUTC: begin
                     if (cmd_data == 8'h0D)      col_q <= '0;
                     else if (cmd_data == 8'h08) col_q <= (col_q == '0) ? '0 : col_q - 7'd1;
                     else if (printable)         col_q <= (col_q == LAST_COL) ? '0 : col_q + 7'd1;
                     if (do_lf) begin
                        if (row_q < LAST_ROW) row_q <= row_q + 5'd1;
                        else begin
                           // The row leaving the top becomes the new, blank bottom row.
                           top        <= (top == LAST_ROW) ? '0 : top + 5'd1;
                           scroll_row <= top;
                           cnt        <= '0;
                           state      <= ST_SCROLL;
                        end
                     end
                  end
                  OP_SETROW: row_q <= (cmd_data > LAST_ROW8) ? LAST_ROW : cmd_data[4:0];
                  OP_SETCOL: col_q <= (cmd_data > LAST_COL8) ? LAST_COL : cmd_data[6:0];
                  OP_CLEAR: begin
                     state <= ST_CLEAR;
                     cnt   <= '0;
                     row_q <= '0;
                     col_q <= '0;
                     top   <= '0;
                  end
                  default: ;
               endcase
            end
         endcase
      end
   end

   logic [31:0] blink_cnt;
   logic        blink_on;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (blink_cnt == LAST_BLINK) begin
         blink_cnt <= '0;
         blink_on  <= ~blink_on;
      end else begin
         blink_cnt <= blink_cnt + 32'd1;
      end
   end

   logic [6:0]    txt_col;
   logic [5:0]    txt_row;
   logic          in_range, cur_hit;
   logic [AW-1:0] rd_addr;

   assign txt_col  = hpos[9:3];
   assign txt_row  = vpos[9:4];
   assign in_range = (int'(txt_row) < ROWS) && (int'(txt_col) < COLS);
   assign rd_addr  = in_range ? cell_addr(phys_row(int'(txt_row), top), int'(txt_col)) : '0;
   assign cur_hit  = curvis && blink_on && (txt_row == {1'b0, row_q}) && (txt_col == col_q);

   logic [32:0] s1_cell;
   logic        s1_on, s1_hit, s1_blk, s1_hs, s1_vs;
   logic [3:0]  s1_grow;
   logic [2:0]  s1_gcol;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_cell <= '0;
         s1_on   <= 1'b0;
         s1_hit  <= 1'b0;
         s1_blk  <= 1'b0;
         s1_hs   <= 1'b0;
         s1_vs   <= 1'b0;
         s1_grow <= '0;
         s1_gcol <= '0;
      end else begin
         s1_cell <= mem[rd_addr];
         s1_on   <= display_on && in_range;
         s1_hit  <= cur_hit;
         s1_blk  <= curblk;
         s1_hs   <= hsync_in;
         s1_vs   <= vsync_in;
         s1_grow <= vpos[3:0];
         s1_gcol <= hpos[2:0];
      end
   end

   logic [11:0] fg, bg, pix, rgb_q;
   logic [7:0]  glyph;
   logic        lit;

   always_comb begin
      fg = s1_cell[31:20];
      bg = s1_cell[19:8];
      if (s1_hit && s1_blk) begin
         fg = s1_cell[19:8];
         bg = s1_cell[31:20];
      end
      glyph = font_row(s1_cell[7:0], s1_grow);
      // Glyph column 0 is the leftmost pixel, i.e. the font MSB.
      if (s1_grow < 4'd12)       lit = glyph[~s1_gcol];
      else if (s1_grow == 4'd13) lit = s1_cell[32];
      else if (s1_grow >= 4'd14) lit = s1_hit && !s1_blk;
      else                       lit = 1'b0;
      pix = !s1_on ? 12'h000 : (lit ? fg : bg);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb_q <= '0;
         hsync <= 1'b0;
         vsync <= 1'b0;
      end else begin
         rgb_q <= pix;
         hsync <= s1_hs;
         vsync <= s1_vs;
      end
   end

   assign red   = rgb_q[11:8];
   assign green = rgb_q[7:4];
   assign blue  = rgb_q[3:0];
endmodule

// File: tb/tb_vga_terminal.sv
// Directed bench for vga_terminal: command sequences plus pixel probes scored
// through a queue of expected {hsync, vsync, rgb} values.
module tb_vga_terminal;
   localparam int COLS      = 80;
   localparam int ROWS      = 30;
   localparam int BLINK_DIV = 64;
   localparam int CELLS     = COLS * ROWS;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  hpos, vpos;
   logic        display_on, hsync_in, vsync_in;
   logic        cmd_valid, cmd_ready;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_data;
   logic [11:0] fgclr, bgclr;
   logic        underln, curvis, curblk;
   logic [4:0]  cur_row;
   logic [6:0]  cur_col;
   logic        hsync, vsync;
   logic [3:0]  red, green, blue;

   int          checks = 0;
   int          errors = 0;
   int          n;
   string       tag_q[$];
   logic [13:0] exp_q[$];

   // Reference blink phase: toggles every BLINK_DIV cycles, on after reset.
   int          bcnt;
   logic        bph;

   always #5 clk = ~clk;

   vga_terminal #(.COLS(COLS), .ROWS(ROWS), .BLINK_DIV(BLINK_DIV)) dut (
      .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
      .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .fgclr(fgclr), .bgclr(bgclr), .underln(underln),
      .curvis(curvis), .curblk(curblk), .cur_row(cur_row), .cur_col(cur_col),
      .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
   );

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bcnt <= 0;
         bph  <= 1'b1;
      end else if (bcnt == BLINK_DIV - 1) begin
         bcnt <= 0;
         bph  <= ~bph;
      end else begin
         bcnt <= bcnt + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] d);
      int w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 5000) begin
         @(negedge clk);
         w++;
      end
      check("send_ready_wait", 32'(w >= 5000), 32'd0);
      cmd_op    = op;
      cmd_data  = d;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // Posedges from now until cmd_ready is seen high just after an edge.
   task automatic busy_cycles(output int cnt);
      cnt = 0;
      do begin
         @(posedge clk);
         #1 cnt++;
      end while (!cmd_ready && cnt < 6000);
   endtask

   task automatic wait_blink(input logic want);
      int w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(bph == want && bcnt >= 2 && bcnt < BLINK_DIV - 10) && w < 4 * BLINK_DIV);
      check("blink_wait_bound", 32'(w >= 4 * BLINK_DIV), 32'd0);
   endtask

   // Probe one pixel; a filler cycle with different sync/blank values follows
   // so the sample two edges later can only match the probed pixel.
   task automatic pix(input string tag, input int row, input int col, input int grow,
                      input int gcol, input logic don, input logic [11:0] exp);
      string       t;
      logic [13:0] e;
      @(negedge clk);
      hpos       = 10'(col * 8 + gcol);
      vpos       = 10'(row * 16 + grow);
      display_on = don;
      hsync_in   = 1'b1;
      vsync_in   = 1'b0;
      tag_q.push_back(tag);
      exp_q.push_back({1'b1, 1'b0, exp});
      @(negedge clk);
      display_on = 1'b0;
      hsync_in   = 1'b0;
      vsync_in   = 1'b1;
      @(negedge clk);
      vsync_in = 1'b0;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      assert ({hsync, vsync, red, green, blue} === e) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", t, {hsync, vsync, red, green, blue}, e);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      hpos       = '0;
      vpos       = '0;
      display_on = 1'b1;
      hsync_in   = 1'b1;
      vsync_in   = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = '0;
      cmd_data   = '0;
      fgclr      = '0;
      bgclr      = '0;
      underln    = 1'b0;
      curvis     = 1'b0;
      curblk     = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_rgb", 32'({red, green, blue}), 32'd0);
      check("rst_sync", 32'({hsync, vsync}), 32'd0);
      check("rst_cursor", 32'({cur_row, cur_col}), 32'd0);

      display_on = 1'b0;
      hsync_in   = 1'b0;
      vsync_in   = 1'b0;
      reset_n    = 1'b1;
      busy_cycles(n);
      check("init_clear_cycles", 32'(n), 32'(CELLS));
      pix("blank_r0c0", 0, 0, 1, 3, 1'b1, 12'h000);
      pix("blank_r29c79", 29, 79, 5, 4, 1'b1, 12'h000);

      // Write 'A' in the last column: wraps to the next row.
      fgclr = 12'hFFF;
      bgclr = 12'h00F;
      send(3'd1, 8'd5);
      send(3'd2, 8'd79);
      send(3'd0, 8'h41);
      check("putc_wrap_cursor", 32'({cur_row, cur_col}), 32'({5'd6, 7'd0}));
      check("putc_ready", 32'(cmd_ready), 32'd1);
      pix("a_lit", 5, 79, 1, 3, 1'b1, 12'hFFF);
      pix("a_bg", 5, 79, 1, 0, 1'b1, 12'h00F);
      pix("a_row12", 5, 79, 12, 3, 1'b1, 12'h00F);
      pix("a_row13_noul", 5, 79, 13, 0, 1'b1, 12'h00F);
      pix("a_display_off", 5, 79, 1, 3, 1'b0, 12'h000);
      pix("offscreen_col", 5, 100, 1, 3, 1'b1, 12'h000);
      pix("offscreen_row", 40, 0, 1, 3, 1'b1, 12'h000);

      underln = 1'b1;
      fgclr   = 12'h0F0;
      bgclr   = 12'h001;
      send(3'd0, 8'h41);
      underln = 1'b0;
      check("putc_advance", 32'({cur_row, cur_col}), 32'({5'd6, 7'd1}));
      pix("ul_row13", 6, 0, 13, 0, 1'b1, 12'h0F0);
      pix("ul_row12", 6, 0, 12, 0, 1'b1, 12'h001);

      // Fill rows 0 and 1, then line feed on the last row to scroll.
      fgclr = 12'hF0F;
      bgclr = 12'h111;
      send(3'd1, 8'd0);
      send(3'd2, 8'd0);
      send(3'd0, 8'h42);
      fgclr = 12'h0F0;
      bgclr = 12'h222;
      send(3'd1, 8'd1);
      send(3'd2, 8'd0);
      send(3'd0, 8'h41);
      pix("pre_scroll_r0", 0, 0, 2, 1, 1'b1, 12'hF0F);
      send(3'd1, 8'd29);
      send(3'd2, 8'd10);
      send(3'd0, 8'h0A);
      busy_cycles(n);
      check("scroll_cycles", 32'(n), 32'(COLS));
      check("scroll_cursor", 32'({cur_row, cur_col}), 32'({5'd29, 7'd10}));
      pix("scroll_r0_lit", 0, 0, 1, 3, 1'b1, 12'h0F0);
      pix("scroll_r0_bg", 0, 0, 1, 0, 1'b1, 12'h222);
      pix("scroll_bottom_blank", 29, 0, 5, 0, 1'b1, 12'h000);
      pix("scroll_r4_a", 4, 79, 1, 3, 1'b1, 12'hFFF);

      // Backspace and carriage return move the cursor without writing.
      fgclr = 12'hABC;
      bgclr = 12'h000;
      send(3'd1, 8'd3);
      send(3'd2, 8'd0);
      send(3'd0, 8'h08);
      check("bs_saturate", 32'({cur_row, cur_col}), 32'({5'd3, 7'd0}));
      pix("bs_nowrite", 3, 0, 2, 1, 1'b1, 12'h000);
      send(3'd2, 8'd40);
      send(3'd0, 8'h0D);
      check("cr_cursor", 32'({cur_row, cur_col}), 32'({5'd3, 7'd0}));
      pix("cr_nowrite", 3, 40, 2, 1, 1'b1, 12'h000);
      send(3'd2, 8'd7);
      send(3'd0, 8'h08);
      check("bs_step", 32'(cur_col), 32'd6);

      send(3'd1, 8'd200);
      check("setrow_clamp", 32'(cur_row), 32'd29);
      send(3'd2, 8'd255);
      check("setcol_clamp", 32'(cur_col), 32'd79);
      send(3'd5, 8'h11);
      check("op5_ignored", 32'({cur_row, cur_col, cmd_ready}), 32'({5'd29, 7'd79, 1'b1}));

      // Cursor over a red-on-black space.
      fgclr = 12'hF00;
      bgclr = 12'h000;
      send(3'd1, 8'd2);
      send(3'd2, 8'd5);
      send(3'd0, 8'h20);
      send(3'd2, 8'd5);
      curvis = 1'b1;
      curblk = 1'b1;
      wait_blink(1'b1);
      pix("cur_block_on", 2, 5, 4, 2, 1'b1, 12'hF00);
      wait_blink(1'b0);
      pix("cur_block_off", 2, 5, 4, 2, 1'b1, 12'h000);
      curblk = 1'b0;
      wait_blink(1'b1);
      pix("cur_line_row14", 2, 5, 14, 0, 1'b1, 12'hF00);
      pix("cur_line_row3", 2, 5, 3, 0, 1'b1, 12'h000);
      curvis = 1'b0;

      send(3'd3, 8'h00);
      busy_cycles(n);
      check("clear_cmd_cycles", 32'(n), 32'(CELLS));
      check("clear_cursor", 32'({cur_row, cur_col}), 32'd0);
      pix("clear_r5c79", 5, 79, 1, 3, 1'b1, 12'h000);

      // Reset part-way through CLEAR must restart the whole clear.
      fgclr = 12'h0FF;
      bgclr = 12'h0F0;
      send(3'd1, 8'd20);
      send(3'd2, 8'd0);
      send(3'd0, 8'h41);
      pix("pre_abort_r20", 20, 0, 1, 0, 1'b1, 12'h0F0);
      send(3'd3, 8'h00);
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      repeat (100) @(posedge clk);
      #1 check("pre_reset_sync", 32'({hsync, vsync}), 32'd3);
      #1 reset_n = 1'b0;
      #1 check("async_reset_outputs",
               32'({red, green, blue, hsync, vsync, cmd_ready, cur_row, cur_col}), 32'd0);
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      busy_cycles(n);
      check("abort_clear_cycles", 32'(n), 32'(CELLS));
      pix("abort_r20_blank", 20, 0, 1, 0, 1'b1, 12'h000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_terminal.md
VGA_TERMINAL -- requirements
Module: vga_terminal

Interface
REQ-001 Parameter COLS, default 80, meaning text columns (1..128).
REQ-002 Parameter ROWS, default 30, meaning text rows (1..32).
REQ-003 Parameter BLINK_DIV, default 12500000, meaning clk cycles per cursor blink half-period.
REQ-004 Port clk  in  1  pixel clock (25 MHz); all state SHALL change only on its rising edge, except on reset.
REQ-005 Port reset_n  in  1  asynchronous, active-low reset.
REQ-006 Ports hpos, vpos  in  10 each  pixel position from the hvsync generator; display_on  in  1; hsync_in, vsync_in  in  1 each.
REQ-007 Ports cmd_valid  in  1; cmd_ready  out  1; cmd_op  in  3; cmd_data  in  8  command handshake.
REQ-008 Ports fgclr, bgclr  in  12 each  (4/4/4 r/g/b); underln, curvis, curblk  in  1 each; sampled on command acceptance or per pixel.
REQ-009 Ports cur_row  out  5; cur_col  out  7; hsync, vsync  out  1 each; red, green, blue  out  4 each.

Function
REQ-010 Buffer SHALL hold ROWS x COLS entries of {underline, fg[11:0], bg[11:0], char[7:0]}, organised as a circular row buffer with a top-row offset register top (0..ROWS-1).
REQ-011 A command SHALL be accepted in a cycle when cmd_valid and cmd_ready are both 1; cmd_ready SHALL be 1 only in state IDLE.
REQ-012 cmd_op 0 PUTC: printable char (0x20..0xFF, 0x00..0x07) written at the cursor with the current fgclr/bgclr/underln, then cur_col+1; at col COLS-1 -> col 0 and line feed.
REQ-013 PUTC 0x0D (CR) -> cur_col 0; 0x0A (LF) -> line feed; 0x08 (BS) -> cur_col-1, saturating at 0; none of these write the buffer.
REQ-014 Line feed: if cur_row < ROWS-1 then cur_row+1; else cur_row unchanged, top <= (top+1) mod ROWS, enter state SCROLL.
REQ-015 cmd_op 1 SETROW: cur_row <= min(cmd_data, ROWS-1); cmd_op 2 SETCOL: cur_col <= min(cmd_data, COLS-1).
REQ-016 cmd_op 3 CLEAR: enter state CLEAR, cursor to (0,0), top <= 0; cmd_op 4..7 SHALL be accepted and ignored.
REQ-017 States: IDLE, CLEAR, SCROLL; CLEAR writes zero to all ROWS*COLS entries, one per cycle, then IDLE (busy exactly ROWS*COLS cycles).
REQ-018 SCROLL writes zero to the COLS entries of the new bottom logical row, one per cycle, then IDLE (busy exactly COLS cycles).
REQ-019 Writes in SCROLL/CLEAR and PUTC SHALL use physical row (logical_row + top) mod ROWS; the display path SHALL use the same mapping.
REQ-020 Display path: text col = hpos[9:3], text row = vpos[9:4], glyph row = vpos[3:0], glyph col = hpos[2:0], MSB leftmost.
REQ-021 Pixel pipeline latency SHALL be exactly 2 clk cycles from hpos/vpos/display_on to red/green/blue; hsync/vsync SHALL be hsync_in/vsync_in delayed 2 cycles.
REQ-022 Pixel colour: display_on=0 or text position outside COLS x ROWS -> 0; glyph row < 12 -> fg if font bit set else bg; glyph row 13 with underline bit -> fg; otherwise bg; each cell uses its own stored colours.
REQ-023 Cursor: when curvis=1, blink phase on, and cell equals (cur_row, cur_col): curblk=1 -> fg and bg swapped for the whole cell; curblk=0 -> glyph rows 14..15 shown in fg.
REQ-024 Blink phase SHALL toggle every BLINK_DIV cycles from a free-running counter.
REQ-025 Display reads SHALL continue during CLEAR/SCROLL; transient content during those states is unspecified.

Reset
REQ-026 On reset_n=0: cursor (0,0), top 0, blink counter 0, phase on, pipeline registers 0, red/green/blue/hsync/vsync 0, cmd_ready 0.
REQ-027 On reset release SHALL enter CLEAR; cmd_ready SHALL rise after ROWS*COLS cycles.
REQ-028 Reset asserted mid-CLEAR or mid-SCROLL SHALL abort the operation and restart CLEAR on release.

Verification
REQ-029 Release reset -> cmd_ready 0 for 2400 cycles, then 1; all cells read 0.
REQ-030 SETROW 5, SETCOL 79, PUTC 0x41 fg 0xFFF -> cell (5,79)=0x41, cursor (6,0); pixel of 'A' lit row shows 0xFFF two cycles later.
REQ-031 Cursor (29,10), PUTC 0x0A -> cur_row 29, top 1, cmd_ready 0 for 80 cycles; old row 1 now displayed at text row 0, bottom row blank.
REQ-032 Cursor (3,0), PUTC 0x08 -> cursor (3,0); PUTC 0x0D at (3,40) -> (3,0); no buffer change.
REQ-033 curvis=1, curblk=1, blink on, cursor cell char 0x20 bg 0x000 fg 0xF00 -> cell pixels read 0xF00; blink off -> 0x000.
REQ-034 Assert reset_n low 100 cycles into CLEAR -> outputs 0 immediately; release -> full 2400-cycle CLEAR repeats.
